picobello_mcast_b_join: RTL

// - Response-side counterpart of the multicast request encoding (mcast_mask in the AXI user field).
// - Sits at the narrow AXI initiator port of the NoC, next to the request fork.
// - Per accepted multicast write: decodes addr+mask into the set of destination cluster tiles.
// - Collects one B response from every destination, merges the resp codes, and returns a

---
 rtl/picobello_mcast_b_join_pkg.sv | 33 +++
 rtl/picobello_mcast_b_join_if.sv | 33 +++
 rtl/picobello_mcast_b_join_dst_decode.sv | 38 +++
 rtl/picobello_mcast_b_join.sv | 96 +++++++++
 4 files changed

// File: rtl/picobello_mcast_b_join_pkg.sv
// Shared types for the multicast B-join: destination mask, tracking entry and AXI resp merge.
package picobello_mcast_b_join_pkg;

  localparam int unsigned McastNumX    = 4;
  localparam int unsigned McastNumY    = 4;
  localparam int unsigned McastNumDst  = McastNumX * McastNumY;
  localparam int unsigned McastIdWidth = 4;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RespOkay   = 2'b00;
  localparam axi_resp_t RespExOkay = 2'b01;
  localparam axi_resp_t RespSlvErr = 2'b10;
  localparam axi_resp_t RespDecErr = 2'b11;

  typedef logic [McastNumDst-1:0] mcast_dst_mask_t;

  typedef struct packed {
    logic                    valid;
    logic [McastIdWidth-1:0] id;
    mcast_dst_mask_t         pending;
    axi_resp_t               resp;
  } mcast_entry_t;

  // EXOKAY has no meaning for a multicast, so it folds into OKAY before taking the worst code.
  function automatic axi_resp_t resp_merge(axi_resp_t a, axi_resp_t b);
    axi_resp_t na, nb;
    na = (a == RespExOkay) ? RespOkay : a;
    nb = (b == RespExOkay) ? RespOkay : b;
    return (na > nb) ? na : nb;
  endfunction

endpackage

// File: rtl/picobello_mcast_b_join_if.sv
// Request / per-destination response / merged B bundle of the multicast B-join.
interface picobello_mcast_b_join_if #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned SrcWidth  = 4
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic [AddrWidth-1:0] req_mask_i;
  logic [IdWidth-1:0]   req_id_i;
  logic                 rsp_valid_i;
  logic                 rsp_ready_o;
  logic [SrcWidth-1:0]  rsp_src_i;
  logic [1:0]           rsp_resp_i;
  logic                 b_valid_o;
  logic                 b_ready_i;
  logic [IdWidth-1:0]   b_id_o;
  logic [1:0]           b_resp_o;
  logic                 err_unexp_o;

  modport master (
    output req_valid_i, req_addr_i, req_mask_i, req_id_i,
    output rsp_valid_i, rsp_src_i, rsp_resp_i, b_ready_i,
    input  req_ready_o, rsp_ready_o, b_valid_o, b_id_o, b_resp_o, err_unexp_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_mask_i, req_id_i,
    input  rsp_valid_i, rsp_src_i, rsp_resp_i, b_ready_i,
    output req_ready_o, rsp_ready_o, b_valid_o, b_id_o, b_resp_o, err_unexp_o
  );
endinterface

// File: rtl/picobello_mcast_b_join_dst_decode.sv
// Combinational addr+mask -> set of destination tiles; shared with the request fork.
module picobello_mcast_b_join_dst_decode #(
  parameter int unsigned NumX      = 4,
  parameter int unsigned NumY      = 4,
  parameter int unsigned OffsetX   = 20,
  parameter int unsigned LenX      = 2,
  parameter int unsigned OffsetY   = 18,
  parameter int unsigned LenY      = 2,
  parameter int unsigned AddrWidth = 48
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] mask_i,
  output logic [NumX*NumY-1:0] dst_o
);
  logic [LenX-1:0] ax, mx;
  logic [LenY-1:0] ay, my;
  logic            unused_bits;

  assign ax = addr_i[OffsetX +: LenX];
  assign mx = mask_i[OffsetX +: LenX];
  assign ay = addr_i[OffsetY +: LenY];
  assign my = mask_i[OffsetY +: LenY];
  assign unused_bits = ^{addr_i, mask_i};

  // A tile matches when it agrees with the address on every unmasked coordinate bit;
  // coordinates that cannot be expressed in LenX/LenY bits are never reachable.
  for (genvar gx = 0; gx < NumX; gx++) begin : g_x
    for (genvar gy = 0; gy < NumY; gy++) begin : g_y
      if ((gx < (1 << LenX)) && (gy < (1 << LenY))) begin : g_sel
        localparam logic [LenX-1:0] XC = LenX'(gx);
        localparam logic [LenY-1:0] YC = LenY'(gy);
        assign dst_o[gx*NumY+gy] = ((XC & ~mx) == (ax & ~mx)) && ((YC & ~my) == (ay & ~my));
      end else begin : g_none
        assign dst_o[gx*NumY+gy] = 1'b0;
      end
    end
  end
endmodule

// File: rtl/picobello_mcast_b_join.sv
// Joins the per-tile B responses of each multicast write into one in-order merged B.
module picobello_mcast_b_join
  import picobello_mcast_b_join_pkg::*;
#(
  parameter int unsigned NumX      = McastNumX,
  parameter int unsigned NumY      = McastNumY,
  parameter int unsigned OffsetX   = 20,
  parameter int unsigned LenX      = 2,
  parameter int unsigned OffsetY   = 18,
  parameter int unsigned LenY      = 2,
  parameter int unsigned MaxTxns   = 4,
  parameter int unsigned IdWidth   = McastIdWidth,
  parameter int unsigned AddrWidth = 48
) (
  input logic clk_i,
  input logic rst_ni,
  picobello_mcast_b_join_if.slave bus
);
  localparam int unsigned NumDst = NumX * NumY;
  localparam int unsigned PtrW   = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned CntW   = $clog2(MaxTxns + 1);

  mcast_entry_t    tbl [MaxTxns];
  logic [PtrW-1:0] head, tail, hit_idx, idx;
  logic [CntW-1:0] cnt;
  mcast_dst_mask_t dec_mask;
  logic            alloc, pop, hit, b_valid, err_q;

  picobello_mcast_b_join_dst_decode #(
    .NumX(NumX), .NumY(NumY), .OffsetX(OffsetX), .LenX(LenX),
    .OffsetY(OffsetY), .LenY(LenY), .AddrWidth(AddrWidth)
  ) i_decode (
    .addr_i (bus.req_addr_i),
    .mask_i (bus.req_mask_i),
    .dst_o  (dec_mask)
  );

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (32'(p) == MaxTxns - 1) ? '0 : p + 1'b1;
  endfunction

  // No bypass when full: a same-cycle pop frees the slot only for the next cycle.
  assign bus.req_ready_o = (cnt != CntW'(MaxTxns));
  assign bus.rsp_ready_o = 1'b1;
  assign alloc           = bus.req_valid_i && bus.req_ready_o;

  assign b_valid         = tbl[head].valid && (tbl[head].pending == '0);
  assign pop             = b_valid && bus.b_ready_i;
  assign bus.b_valid_o   = b_valid;
  assign bus.b_id_o      = b_valid ? tbl[head].id : '0;
  assign bus.b_resp_o    = b_valid ? tbl[head].resp : RespOkay;
  assign bus.err_unexp_o = err_q;

  // Oldest-first search: walk from head so the response lands on the earliest write still waiting on that tile.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 0; k < MaxTxns; k++) begin
      idx = PtrW'((32'(head) + 32'(k)) % MaxTxns);
      if (!hit && tbl[idx].valid && tbl[idx].pending[bus.rsp_src_i]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxTxns; i++) tbl[i] <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= bus.rsp_valid_i && !hit;
      if (bus.rsp_valid_i && hit) begin
        tbl[hit_idx].pending[bus.rsp_src_i] <= 1'b0;
        tbl[hit_idx].resp <= resp_merge(tbl[hit_idx].resp, bus.rsp_resp_i);
      end
      // An empty destination set completes immediately as a decode error.
      if (alloc) begin
        tbl[tail] <= '{valid:   1'b1,
                       id:      bus.req_id_i,
                       pending: dec_mask,
                       resp:    (dec_mask == '0) ? RespDecErr : RespOkay};
        tail <= ptr_inc(tail);
      end
      if (pop) begin
        tbl[head].valid <= 1'b0;
        head <= ptr_inc(head);
      end
      cnt <= cnt + CntW'(alloc) - CntW'(pop);
    end
  end
endmodule
